// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU sequencer and its regs/ALU datapath.
// Flag vector layout is {Z, C, N, V}, forwarded from the ALU unmodified.
package alu_seq_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned SEL_WIDTH  = 4;
    localparam int unsigned UOP_WIDTH  = 5;
    localparam int unsigned FLAG_W     = 4;

    localparam int unsigned FLAG_Z = 3;
    localparam int unsigned FLAG_C = 2;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_V = 0;

    localparam logic [UOP_WIDTH-1:0] UOP_PASS = 5'b00000;
    localparam logic [UOP_WIDTH-1:0] UOP_ADD  = 5'b00001;
    localparam logic [UOP_WIDTH-1:0] UOP_SUB  = 5'b00010;
    localparam logic [UOP_WIDTH-1:0] UOP_AND  = 5'b00011;
    localparam logic [UOP_WIDTH-1:0] UOP_OR   = 5'b00100;
    localparam logic [UOP_WIDTH-1:0] UOP_XOR  = 5'b00101;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StExec,
        StWb
    } seq_state_e;

endpackage

// File: rtl/alu_sequencer.sv
// Sequences one regs/ALU operation at a time: accept, read operands, execute, write back.
// Selects and data outputs always reflect latched values; strobes fire only in write-back.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_WIDTH,
    parameter int unsigned SEL_W  = SEL_WIDTH,
    parameter int unsigned UOP_W  = UOP_WIDTH
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [SEL_W-1:0]  instr_rd,
    input  logic [SEL_W-1:0]  instr_rn,
    input  logic [SEL_W-1:0]  instr_rm,
    input  logic [UOP_W-1:0]  instr_uop,
    input  logic              instr_imm_en,
    input  logic [DATA_W-1:0] instr_imm,
    input  logic              instr_wb,
    input  logic              instr_setflags,
    output logic [SEL_W-1:0]  sel_p0,
    output logic [SEL_W-1:0]  sel_p1,
    input  logic [DATA_W-1:0] p0,
    input  logic [DATA_W-1:0] p1,
    output logic [SEL_W-1:0]  sel_in,
    output logic [DATA_W-1:0] in_reg,
    output logic              reg_we,
    output logic [DATA_W-1:0] alu_lhs,
    output logic [DATA_W-1:0] alu_rhs,
    output logic [UOP_W-1:0]  alu_uop,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [FLAG_W-1:0] alu_flags,
    output logic [FLAG_W-1:0] flags_in,
    output logic              flags_we,
    output logic              done
);

    seq_state_e state_q, state_d;

    logic [SEL_W-1:0]  rd_q, rn_q, rm_q;
    logic [UOP_W-1:0]  uop_q;
    logic              imm_en_q, wb_q, setflags_q;
    logic [DATA_W-1:0] imm_q, lhs_q, rhs_q, res_q;
    logic [FLAG_W-1:0] flg_q;
    logic              accept;

    assign accept = instr_valid && instr_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StRead;
            StRead:  state_d = StExec;
            StExec:  state_d = StWb;
            StWb:    state_d = accept ? StRead : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        instr_ready = 1'b0;
        reg_we      = 1'b0;
        flags_we    = 1'b0;
        done        = 1'b0;
        unique case (state_q)
            StIdle: instr_ready = 1'b1;
            StWb: begin
                instr_ready = 1'b1;
                reg_we      = wb_q;
                flags_we    = setflags_q;
                done        = 1'b1;
            end
            default: ;
        endcase
    end

    // An instruction accepted in write-back reads one edge later, so it sees the new value.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_q       <= '0;
            rn_q       <= '0;
            rm_q       <= '0;
            uop_q      <= '0;
            imm_en_q   <= 1'b0;
            imm_q      <= '0;
            wb_q       <= 1'b0;
            setflags_q <= 1'b0;
            lhs_q      <= '0;
            rhs_q      <= '0;
            res_q      <= '0;
            flg_q      <= '0;
        end else begin
            if (accept) begin
                rd_q       <= instr_rd;
                rn_q       <= instr_rn;
                rm_q       <= instr_rm;
                uop_q      <= instr_uop;
                imm_en_q   <= instr_imm_en;
                imm_q      <= instr_imm;
                wb_q       <= instr_wb;
                setflags_q <= instr_setflags;
            end
            if (state_q == StRead) begin
                lhs_q <= p0;
                rhs_q <= imm_en_q ? imm_q : p1;
            end
            if (state_q == StExec) begin
                res_q <= alu_out;
                flg_q <= alu_flags;
            end
        end
    end

    assign sel_p0   = rn_q;
    assign sel_p1   = rm_q;
    assign alu_lhs  = lhs_q;
    assign alu_rhs  = rhs_q;
    assign alu_uop  = uop_q;
    assign sel_in   = rd_q;
    assign in_reg   = res_q;
    assign flags_in = flg_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural register file and ALU around the DUT, plus an
// architectural model of the register contents used to predict every retirement.
module tb_alu_sequencer;
    import alu_seq_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [3:0]  instr_rd = '0, instr_rn = '0, instr_rm = '0;
    logic [4:0]  instr_uop = '0;
    logic        instr_imm_en = 1'b0;
    logic [31:0] instr_imm = '0;
    logic        instr_wb = 1'b0, instr_setflags = 1'b0;
    logic [3:0]  sel_p0, sel_p1, sel_in;
    logic [31:0] p0, p1, in_reg, alu_lhs, alu_rhs, alu_out;
    logic [4:0]  alu_uop;
    logic [3:0]  alu_flags, flags_in;
    logic        reg_we, flags_we, done;

    logic [31:0] env_rf [16];
    logic [31:0] mreg [16];
    int n_tests = 0;
    int n_fail = 0;

    logic [3:0]  c_rd, c_rn, c_rm;
    logic [4:0]  c_uop;
    logic        c_ie, c_wb, c_sf;
    logic [31:0] c_imm;

    // Returns {Z, C, N, V, result}; C on subtract means "no borrow".
    function automatic logic [35:0] alu_ref(input logic [4:0] uop, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [32:0] wide;
        logic [31:0] r;
        logic        c, v;
        c = 1'b0;
        v = 1'b0;
        case (uop)
            UOP_ADD: begin
                wide = {1'b0, a} + {1'b0, b};
                r = wide[31:0];
                c = wide[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            UOP_SUB: begin
                r = a - b;
                c = (a >= b);
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            UOP_AND: r = a & b;
            UOP_OR:  r = a | b;
            UOP_XOR: r = a ^ b;
            default: r = b;
        endcase
        return {(r == 32'd0), c, r[31], v, r};
    endfunction

    always #5 clock = ~clock;

    assign p0 = env_rf[sel_p0];
    assign p1 = env_rf[sel_p1];
    assign {alu_flags, alu_out} = alu_ref(alu_uop, alu_lhs, alu_rhs);

    always @(posedge clock) if (reg_we) env_rf[sel_in] <= in_reg;

    alu_sequencer dut (
        .clock(clock), .reset(reset),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_rd(instr_rd), .instr_rn(instr_rn), .instr_rm(instr_rm),
        .instr_uop(instr_uop), .instr_imm_en(instr_imm_en), .instr_imm(instr_imm),
        .instr_wb(instr_wb), .instr_setflags(instr_setflags),
        .sel_p0(sel_p0), .sel_p1(sel_p1), .p0(p0), .p1(p1),
        .sel_in(sel_in), .in_reg(in_reg), .reg_we(reg_we),
        .alu_lhs(alu_lhs), .alu_rhs(alu_rhs), .alu_uop(alu_uop),
        .alu_out(alu_out), .alu_flags(alu_flags),
        .flags_in(flags_in), .flags_we(flags_we), .done(done)
    );

    task automatic set_reg(input logic [3:0] idx, input logic [31:0] v);
        env_rf[idx] <= v;
        mreg[idx] = v;
    endtask

    task automatic drive(input logic [3:0] rd, input logic [3:0] rn, input logic [3:0] rm,
                         input logic [4:0] uop, input logic ie, input logic [31:0] imm,
                         input logic wb, input logic sf);
        instr_rd = rd; instr_rn = rn; instr_rm = rm; instr_uop = uop;
        instr_imm_en = ie; instr_imm = imm; instr_wb = wb; instr_setflags = sf;
        instr_valid = 1'b1;
    endtask

    // Lets the driven instruction be taken at the next edge, then counts cycles to done.
    task automatic accept_wait(output int lat);
        @(posedge clock);
        @(negedge clock);
        instr_valid = 1'b0;
        lat = 1;
        while (!done && lat < 10) begin
            @(negedge clock);
            lat++;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 16; i++) begin
            env_rf[i] <= 32'd0;
            mreg[i] = 32'd0;
        end
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        n_tests++;
        if ({instr_ready, reg_we, flags_we, done} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_strobes: got %b expected 1000",
                     {instr_ready, reg_we, flags_we, done});
        end
        n_tests++;
        if ({sel_p0, sel_p1, sel_in, in_reg, alu_lhs, alu_rhs, alu_uop, flags_in} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {sel_p0, sel_p1, sel_in, in_reg, alu_lhs, alu_rhs, alu_uop, flags_in});
        end
    endtask

    task automatic test_idle();
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            n_tests++;
            if ({instr_ready, reg_we, flags_we, done} !== 4'b1000 ||
                {sel_in, in_reg, alu_lhs, alu_rhs, flags_in} !== '0) begin
                n_fail++;
                $display("FAIL idle_cycle%0d: got strobes %b in_reg %h expected 1000 and 0",
                         i, {instr_ready, reg_we, flags_we, done}, in_reg);
            end
        end
    endtask

    task automatic test_sub_flags();
        int lat;
        set_reg(4'd0, 32'd2);
        set_reg(4'd1, 32'd1);
        drive(4'd2, 4'd1, 4'd0, UOP_SUB, 1'b0, 32'd0, 1'b1, 1'b1);
        accept_wait(lat);
        n_tests++;
        if (lat != 3) begin n_fail++; $display("FAIL sub_latency: got %0d expected 3", lat); end
        n_tests++;
        if ({reg_we, flags_we, sel_in} !== 6'b11_0010) begin
            n_fail++;
            $display("FAIL sub_strobes: got %b expected 110010", {reg_we, flags_we, sel_in});
        end
        n_tests++;
        if (in_reg !== 32'hFFFF_FFFF) begin
            n_fail++; $display("FAIL sub_result: got %h expected ffffffff", in_reg);
        end
        n_tests++;
        if (flags_in[FLAG_N] !== 1'b1 || flags_in[FLAG_Z] !== 1'b0) begin
            n_fail++; $display("FAIL sub_flags: got %b expected N=1 Z=0", flags_in);
        end
        mreg[2] = 32'hFFFF_FFFF;
        @(negedge clock);
        n_tests++;
        if (done !== 1'b0 || instr_ready !== 1'b1 || env_rf[2] !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL sub_commit: got done %b ready %b r2 %h expected 0 1 ffffffff",
                     done, instr_ready, env_rf[2]);
        end
    endtask

    task automatic test_imm();
        int lat;
        set_reg(4'd1, 32'd5);
        drive(4'd3, 4'd1, 4'd0, UOP_SUB, 1'b1, 32'd5, 1'b1, 1'b1);
        accept_wait(lat);
        n_tests++;
        if (lat != 3 || in_reg !== 32'd0 || flags_in[FLAG_Z] !== 1'b1 || flags_we !== 1'b1) begin
            n_fail++;
            $display("FAIL imm_sub: got lat %0d res %h flags %b fwe %b expected 3 0 Z=1 1",
                     lat, in_reg, flags_in, flags_we);
        end
        mreg[3] = 32'd0;
        @(negedge clock);
        n_tests++;
        if (env_rf[3] !== 32'd0) begin
            n_fail++; $display("FAIL imm_commit: got r3 %h expected 0", env_rf[3]);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        set_reg(4'd0, 32'd10);
        set_reg(4'd1, 32'd7);
        set_reg(4'd2, 32'd0);
        drive(4'd2, 4'd0, 4'd1, UOP_ADD, 1'b0, 32'd0, 1'b1, 1'b0);
        @(posedge clock);
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
            if (lat == 1) begin
                n_tests++;
                if (instr_ready !== 1'b0) begin
                    n_fail++; $display("FAIL b2b_busy: got ready %b expected 0", instr_ready);
                end
            end
        end while (!done && lat < 10);
        n_tests++;
        if (lat != 3 || in_reg !== 32'd17) begin
            n_fail++;
            $display("FAIL b2b_first: got lat %0d res %h expected 3 00000011", lat, in_reg);
        end
        mreg[2] = 32'd17;
        drive(4'd4, 4'd2, 4'd2, UOP_ADD, 1'b0, 32'd0, 1'b1, 1'b0);
        accept_wait(lat);
        n_tests++;
        if (lat != 3 || in_reg !== 32'd34 || sel_in !== 4'd4) begin
            n_fail++;
            $display("FAIL b2b_second: got lat %0d res %h rd %0d expected 3 00000022 4",
                     lat, in_reg, sel_in);
        end
        mreg[4] = 32'd34;
        @(negedge clock);
    endtask

    task automatic test_no_wb();
        int lat;
        set_reg(4'd5, 32'h0000_A5A5);
        drive(4'd5, 4'd0, 4'd1, UOP_ADD, 1'b0, 32'd0, 1'b0, 1'b0);
        accept_wait(lat);
        n_tests++;
        if (lat != 3 || done !== 1'b1 || reg_we !== 1'b0 || flags_we !== 1'b0) begin
            n_fail++;
            $display("FAIL nowb_strobes: got lat %0d done %b we %b fwe %b expected 3 1 0 0",
                     lat, done, reg_we, flags_we);
        end
        @(negedge clock);
        n_tests++;
        if (env_rf[5] !== 32'h0000_A5A5) begin
            n_fail++; $display("FAIL nowb_reg: got r5 %h expected 0000a5a5", env_rf[5]);
        end
    endtask

    task automatic test_reset_exec();
        logic saw;
        set_reg(4'd6, 32'h0000_1234);
        drive(4'd6, 4'd0, 4'd1, UOP_ADD, 1'b0, 32'd0, 1'b1, 1'b1);
        @(posedge clock);
        @(negedge clock);
        instr_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        n_tests++;
        if (instr_ready !== 1'b1 || {reg_we, flags_we, done} !== 3'b000 ||
            in_reg !== 32'd0 || alu_lhs !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_exec_state: got ready %b strobes %b res %h lhs %h expected 1 0 0 0",
                     instr_ready, {reg_we, flags_we, done}, in_reg, alu_lhs);
        end
        saw = 1'b0;
        repeat (5) begin
            @(negedge clock);
            saw = saw | reg_we | flags_we | done;
        end
        n_tests++;
        if (saw !== 1'b0 || env_rf[6] !== 32'h0000_1234) begin
            n_fail++;
            $display("FAIL rst_exec_discard: got strobe %b r6 %h expected 0 00001234",
                     saw, env_rf[6]);
        end
    endtask

    task automatic gen_and_drive();
        c_rd  = 4'($urandom_range(0, 15));
        c_rn  = 4'($urandom_range(0, 3));
        c_rm  = 4'($urandom_range(0, 3));
        c_uop = 5'($urandom_range(0, 5));
        c_ie  = ($urandom_range(0, 3) == 0);
        c_imm = $urandom;
        c_wb  = ($urandom_range(0, 3) != 0);
        c_sf  = 1'($urandom_range(0, 1));
        drive(c_rd, c_rn, c_rm, c_uop, c_ie, c_imm, c_wb, c_sf);
    endtask

    task automatic test_random();
        int lat;
        logic pending;
        logic [35:0] exp;
        for (int i = 0; i < 16; i++) set_reg(4'(i), $urandom);
        pending = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!pending) gen_and_drive();
            accept_wait(lat);
            exp = alu_ref(c_uop, mreg[c_rn], c_ie ? c_imm : mreg[c_rm]);
            n_tests++;
            if (lat != 3) begin
                n_fail++; $display("FAIL rand%0d_latency: got %0d expected 3", i, lat);
            end
            n_tests++;
            if ({reg_we, flags_we, sel_in, in_reg, flags_in} !==
                {c_wb, c_sf, c_rd, exp[31:0], exp[35:32]}) begin
                n_fail++;
                $display("FAIL rand%0d_retire: got we %b fwe %b rd %0d res %h fl %b expected %b %b %0d %h %b",
                         i, reg_we, flags_we, sel_in, in_reg, flags_in,
                         c_wb, c_sf, c_rd, exp[31:0], exp[35:32]);
            end
            if (c_wb) mreg[c_rd] = exp[31:0];
            if (i < 39 && $urandom_range(0, 1) == 1) begin
                gen_and_drive();
                pending = 1'b1;
            end else begin
                pending = 1'b0;
                @(negedge clock);
            end
        end
        for (int i = 0; i < 16; i++) begin
            n_tests++;
            if (env_rf[i] !== mreg[i]) begin
                n_fail++;
                $display("FAIL rand_regfile_r%0d: got %h expected %h", i, env_rf[i], mreg[i]);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_idle();
        test_sub_flags();
        test_imm();
        test_back_to_back();
        test_no_wb();
        test_reset_exec();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
